// File: rtl/tl_mem_arbiter_if.sv
// Bundle of requester-side and memory-side TileLink-UL signals for the arbiter.
// slave: the arbiter's view. master: the view of whatever drives the requesters and memory.
interface tl_mem_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int SRC_W  = 4
);
    localparam int MASK_W = DATA_W / 8;

    // requester A channel
    logic [N_REQ-1:0]        req_a_valid_i;
    logic [N_REQ-1:0]        req_a_ready_o;
    logic [N_REQ*3-1:0]      req_a_opcode_i;
    logic [N_REQ*3-1:0]      req_a_param_i;
    logic [N_REQ*3-1:0]      req_a_size_i;
    logic [N_REQ*ADDR_W-1:0] req_a_address_i;
    logic [N_REQ*MASK_W-1:0] req_a_mask_i;
    logic [N_REQ*DATA_W-1:0] req_a_data_i;
    // requester D channel
    logic [N_REQ-1:0]        req_d_valid_o;
    logic [N_REQ-1:0]        req_d_ready_i;
    logic [2:0]              req_d_opcode_o;
    logic [1:0]              req_d_param_o;
    logic [2:0]              req_d_size_o;
    logic                    req_d_denied_o;
    logic [DATA_W-1:0]       req_d_data_o;
    logic                    req_d_corrupt_o;
    // memory A channel
    logic [2:0]              mem_a_opcode_o;
    logic [2:0]              mem_a_param_o;
    logic [2:0]              mem_a_size_o;
    logic [SRC_W-1:0]        mem_a_source_o;
    logic [ADDR_W-1:0]       mem_a_address_o;
    logic [MASK_W-1:0]       mem_a_mask_o;
    logic [DATA_W-1:0]       mem_a_data_o;
    logic                    mem_a_valid_o;
    logic                    mem_a_ready_i;
    // memory D channel
    logic [2:0]              mem_d_opcode_i;
    logic [1:0]              mem_d_param_i;
    logic [2:0]              mem_d_size_i;
    logic [SRC_W-1:0]        mem_d_source_i;
    logic [1:0]              mem_d_sink_i;
    logic                    mem_d_denied_i;
    logic [DATA_W-1:0]       mem_d_data_i;
    logic                    mem_d_corrupt_i;
    logic                    mem_d_valid_i;
    logic                    mem_d_ready_o;
    // status
    logic [N_REQ-1:0]        pending_o;
    logic                    err_o;
    logic [SRC_W-1:0]        err_src_o;

    modport slave (
        input  req_a_valid_i, req_a_opcode_i, req_a_param_i, req_a_size_i,
               req_a_address_i, req_a_mask_i, req_a_data_i, req_d_ready_i,
               mem_a_ready_i, mem_d_opcode_i, mem_d_param_i, mem_d_size_i,
               mem_d_source_i, mem_d_sink_i, mem_d_denied_i, mem_d_data_i,
               mem_d_corrupt_i, mem_d_valid_i,
        output req_a_ready_o, req_d_valid_o, req_d_opcode_o, req_d_param_o,
               req_d_size_o, req_d_denied_o, req_d_data_o, req_d_corrupt_o,
               mem_a_opcode_o, mem_a_param_o, mem_a_size_o, mem_a_source_o,
               mem_a_address_o, mem_a_mask_o, mem_a_data_o, mem_a_valid_o,
               mem_d_ready_o, pending_o, err_o, err_src_o
    );

    modport master (
        output req_a_valid_i, req_a_opcode_i, req_a_param_i, req_a_size_i,
               req_a_address_i, req_a_mask_i, req_a_data_i, req_d_ready_i,
               mem_a_ready_i, mem_d_opcode_i, mem_d_param_i, mem_d_size_i,
               mem_d_source_i, mem_d_sink_i, mem_d_denied_i, mem_d_data_i,
               mem_d_corrupt_i, mem_d_valid_i,
        input  req_a_ready_o, req_d_valid_o, req_d_opcode_o, req_d_param_o,
               req_d_size_o, req_d_denied_o, req_d_data_o, req_d_corrupt_o,
               mem_a_opcode_o, mem_a_param_o, mem_a_size_o, mem_a_source_o,
               mem_a_address_o, mem_a_mask_o, mem_a_data_o, mem_a_valid_o,
               mem_d_ready_o, pending_o, err_o, err_src_o
    );
endinterface

// File: rtl/tl_mem_arbiter.sv
// N_REQ-to-1 TileLink-UL arbiter: round-robin A grant into a registered hold
// stage, one outstanding transaction per requester, D routed back by d_source.
module tl_mem_arbiter #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int SRC_W  = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    tl_mem_arbiter_if.slave bus
);
    localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int MASK_W = DATA_W / 8;

    typedef enum logic {S_IDLE, S_HOLD} state_t;

    state_t             r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   r_win;
    logic [N_REQ-1:0]   r_pending;
    logic               r_err;
    logic [SRC_W-1:0]   r_err_src;

    logic               r_a_valid;
    logic [2:0]         r_a_opcode, r_a_param, r_a_size;
    logic [SRC_W-1:0]   r_a_source;
    logic [ADDR_W-1:0]  r_a_address;
    logic [MASK_W-1:0]  r_a_mask;
    logic [DATA_W-1:0]  r_a_data;

    logic [N_REQ-1:0]   w_elig, w_gnt_oh, w_clr_oh, w_src_oh;
    logic               w_found, w_grant, w_accept;
    logic [IDX_W-1:0]   w_win, w_idx, w_rr_nxt;
    logic               w_hit, w_d_rdy_sel, w_d_fire;
    logic               w_unused;

    assign w_elig   = bus.req_a_valid_i & ~r_pending;
    assign w_unused = ^bus.mem_d_sink_i;

    // first eligible requester at or after rr_ptr, wrapping modulo N_REQ
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = IDX_W'((int'(r_rr_ptr) + k) % N_REQ);
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    // state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // next state: grant from IDLE, release from HOLD on memory accept
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: if (w_found) begin
                w_grant     = 1'b1;
                w_state_nxt = S_HOLD;
            end
            S_HOLD: if (bus.mem_a_ready_i) begin
                w_accept    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_gnt_oh          = w_grant ? (N_REQ'(1) << w_win) : '0;
    assign bus.req_a_ready_o = rst_ni ? w_gnt_oh : '0;
    assign w_rr_nxt          = (r_win == IDX_W'(N_REQ - 1)) ? '0 : r_win + 1'b1;

    // A output stage: capture the winner, hold until the memory accepts
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_a_valid   <= 1'b0;
            r_a_opcode  <= '0;
            r_a_param   <= '0;
            r_a_size    <= '0;
            r_a_source  <= '0;
            r_a_address <= '0;
            r_a_mask    <= '0;
            r_a_data    <= '0;
            r_win       <= '0;
            r_rr_ptr    <= '0;
        end else if (w_grant) begin
            r_a_valid   <= 1'b1;
            r_a_opcode  <= bus.req_a_opcode_i[int'(w_win)*3 +: 3];
            r_a_param   <= bus.req_a_param_i[int'(w_win)*3 +: 3];
            r_a_size    <= bus.req_a_size_i[int'(w_win)*3 +: 3];
            r_a_source  <= SRC_W'(w_win);
            r_a_address <= bus.req_a_address_i[int'(w_win)*ADDR_W +: ADDR_W];
            r_a_mask    <= bus.req_a_mask_i[int'(w_win)*MASK_W +: MASK_W];
            r_a_data    <= bus.req_a_data_i[int'(w_win)*DATA_W +: DATA_W];
            r_win       <= w_win;
        end else if (w_accept) begin
            r_a_valid   <= 1'b0;
            r_rr_ptr    <= w_rr_nxt;
        end
    end

    // D decode: a response only counts when its source is in range and pending
    always_comb begin
        w_hit       = 1'b0;
        w_d_rdy_sel = 1'b1;
        w_src_oh    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (int'(bus.mem_d_source_i) == i) begin
                w_src_oh[i] = 1'b1;
                w_hit       = bus.mem_d_valid_i & r_pending[i];
                w_d_rdy_sel = bus.req_d_ready_i[i];
            end
        end
    end

    assign w_d_fire          = w_hit & w_d_rdy_sel;
    assign w_clr_oh          = w_d_fire ? w_src_oh : '0;
    assign bus.req_d_valid_o = (rst_ni & w_hit) ? w_src_oh : '0;
    // stray responses are swallowed so they cannot wedge the memory port
    assign bus.mem_d_ready_o = rst_ni & (w_hit ? w_d_rdy_sel : 1'b1);

    // outstanding flags: grant sets, completed D clears (never the same index)
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_pending <= '0;
        else         r_pending <= (r_pending & ~w_clr_oh) | w_gnt_oh;
    end

    // sticky error capturing the source of the first dropped response
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err     <= 1'b0;
            r_err_src <= '0;
        end else if (bus.mem_d_valid_i && !w_hit && !r_err) begin
            r_err     <= 1'b1;
            r_err_src <= bus.mem_d_source_i;
        end
    end

    assign bus.req_d_opcode_o  = bus.mem_d_opcode_i;
    assign bus.req_d_param_o   = bus.mem_d_param_i;
    assign bus.req_d_size_o    = bus.mem_d_size_i;
    assign bus.req_d_denied_o  = bus.mem_d_denied_i;
    assign bus.req_d_data_o    = bus.mem_d_data_i;
    assign bus.req_d_corrupt_o = bus.mem_d_corrupt_i;

    assign bus.mem_a_valid_o   = r_a_valid;
    assign bus.mem_a_opcode_o  = r_a_opcode;
    assign bus.mem_a_param_o   = r_a_param;
    assign bus.mem_a_size_o    = r_a_size;
    assign bus.mem_a_source_o  = r_a_source;
    assign bus.mem_a_address_o = r_a_address;
    assign bus.mem_a_mask_o    = r_a_mask;
    assign bus.mem_a_data_o    = r_a_data;

    assign bus.pending_o       = r_pending;
    assign bus.err_o           = r_err;
    assign bus.err_src_o       = r_err_src;
endmodule
